byte_lane_wr_fmt: RTL

- Write-burst formatter that sits directly upstream of the DDR3 byte lane.
- Converts a write request plus a per-clk_div-cycle data stream into the lane's din, din_dm, tin_dq, din_dqs and tin_dqs slices.
- Generates DQS preamble, toggling and postamble, and the DQ/DM tristate window.
- Supports seamless back-to-back bursts with continuous DQS.

---
 rtl/byte_lane_wr_fmt.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/byte_lane_wr_fmt.sv
// byte_lane_wr_fmt
// ----------------
// Write-burst formatter feeding one DDR3 byte lane. A write request plus a
// per-clk_div-cycle data stream becomes the lane's din / din_dm / tin_dq /
// din_dqs / tin_dqs slices (4 time slots per clk_div cycle, slot 0 first on
// the wire). Generates DQS preamble, toggling and postamble and the DQ/DM
// drive window. Back-to-back bursts run seamlessly with continuous DQS.
//
// Optional build macro: BYTE_LANE_WR_FMT_WLEV_EN
//   Adds the wlev_pulse input and a one-cycle WLEV state that emits a single
//   DQS rising edge for write leveling.
//
// Ports
//   clk_div     in   sole clock, rising edge
//   rst         in   asynchronous active-high reset
//   wr_start    in   burst request; accepted only while ready=1
//   wr_len      in   data cycles minus 1, sampled with an accepted wr_start
//   wr_data     in   32-bit slot-major lane data (bit 8*k+i = DQ i, slot k)
//   wr_dm       in   data mask per slot
//   wlev_pulse  in   (macro only) write-leveling pulse request
//   data_req    out  wr_data/wr_dm are consumed at the end of this cycle
//   ready       out  wr_start would be accepted this cycle
//   busy        out  state is not IDLE
//   start_err   out  one-cycle pulse: wr_start arrived while not ready
//   din         out  lane DQ data slices
//   din_dm      out  lane DM slices
//   tin_dq      out  per-slot DQ/DM tristate (1 = high-Z)
//   din_dqs     out  per-slot DQS value
//   tin_dqs     out  per-slot DQS tristate (1 = high-Z)
//
// State table
//   state  | meaning
//   IDLE   | lane released, waiting for a request
//   PRE    | DQS preamble (slots 2,3 driven low), first data fetched
//   DATA   | DQ driven, DQS toggling, cnt = data cycles left after this one
//   POST   | DQS postamble (slots 0,1 driven low)
//   WLEV   | (macro only) single DQS rising edge for write leveling

module byte_lane_wr_fmt #(
  parameter int LEN_BITS = 4
) (
  input  logic                clk_div,
  input  logic                rst,
  input  logic                wr_start,
  input  logic [LEN_BITS-1:0] wr_len,
  input  logic [31:0]         wr_data,
  input  logic [3:0]          wr_dm,
`ifdef BYTE_LANE_WR_FMT_WLEV_EN
  input  logic                wlev_pulse,
`endif
  output logic                data_req,
  output logic                ready,
  output logic                busy,
  output logic                start_err,
  output logic [31:0]         din,
  output logic [3:0]          din_dm,
  output logic [3:0]          tin_dq,
  output logic [3:0]          din_dqs,
  output logic [3:0]          tin_dqs
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_DATA = 3'd2,
    S_POST = 3'd3
`ifdef BYTE_LANE_WR_FMT_WLEV_EN
    ,
    S_WLEV = 3'd4
`endif
  } state_t;

  localparam logic [LEN_BITS-1:0] CNT_ONE = {{(LEN_BITS-1){1'b0}}, 1'b1};

  state_t              state;
  state_t              state_nxt;
  logic [LEN_BITS-1:0] cnt;
  logic [LEN_BITS-1:0] cnt_nxt;
  logic                accept;
  logic                last_data;

  logic                data_req_q;
  logic                data_req_nxt;
  logic                start_err_nxt;
  logic [31:0]         din_nxt;
  logic [3:0]          din_dm_nxt;
  logic [3:0]          tin_dq_nxt;
  logic [3:0]          din_dqs_nxt;
  logic [3:0]          tin_dqs_nxt;

  assign last_data = (state == S_DATA) && (cnt == '0);
  assign ready     = (state == S_IDLE) || last_data;
  assign accept    = wr_start && ready;
  assign busy      = (state != S_IDLE);

  // A seamless follow-on request arrives in the same cycle its first data
  // word has to be fetched, so that one fetch cannot come from a register.
  assign data_req  = data_req_q || (last_data && wr_start);

  // --------------------------------------------------------------------
  // Next state and counter
  // --------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = S_PRE;
          cnt_nxt   = wr_len;
        end
`ifdef BYTE_LANE_WR_FMT_WLEV_EN
        else if (wlev_pulse) begin
          state_nxt = S_WLEV;
        end
`endif
      end
      S_PRE: begin
        state_nxt = S_DATA;
      end
      S_DATA: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_ONE;
        end else if (accept) begin
          cnt_nxt = wr_len;
        end else begin
          state_nxt = S_POST;
        end
      end
      S_POST: begin
        state_nxt = S_IDLE;
      end
`ifdef BYTE_LANE_WR_FMT_WLEV_EN
      S_WLEV: begin
        state_nxt = S_IDLE;
      end
`endif
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // --------------------------------------------------------------------
  // Registered outputs: decoded from the state being entered, so each
  // output register holds the value belonging to the current state.
  // --------------------------------------------------------------------
  always_comb begin
    tin_dq_nxt    = 4'hf;
    tin_dqs_nxt   = 4'hf;
    din_dqs_nxt   = 4'h0;
    din_nxt       = 32'h0;
    din_dm_nxt    = 4'h0;
    data_req_nxt  = 1'b0;
    start_err_nxt = wr_start && !ready;
    case (state_nxt)
      S_PRE: begin
        tin_dqs_nxt  = 4'b0011;
        data_req_nxt = 1'b1;
      end
      S_DATA: begin
        tin_dq_nxt   = 4'h0;
        tin_dqs_nxt  = 4'h0;
        din_dqs_nxt  = 4'b0101;
        din_nxt      = wr_data;
        din_dm_nxt   = wr_dm;
        data_req_nxt = (cnt_nxt != '0);
      end
      S_POST: begin
        tin_dqs_nxt = 4'b1100;
      end
`ifdef BYTE_LANE_WR_FMT_WLEV_EN
      S_WLEV: begin
        tin_dqs_nxt = 4'h0;
        din_dqs_nxt = 4'b0010;
      end
`endif
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      din        <= 32'h0;
      din_dm     <= 4'h0;
      tin_dq     <= 4'hf;
      din_dqs    <= 4'h0;
      tin_dqs    <= 4'hf;
      data_req_q <= 1'b0;
      start_err  <= 1'b0;
    end else begin
      din        <= din_nxt;
      din_dm     <= din_dm_nxt;
      tin_dq     <= tin_dq_nxt;
      din_dqs    <= din_dqs_nxt;
      tin_dqs    <= tin_dqs_nxt;
      data_req_q <= data_req_nxt;
      start_err  <= start_err_nxt;
    end
  end

endmodule
